// File: rtl/memory_array_sync_pkg.sv
// Shared types and constants for the synchronous RAM and its read pipeline.
package memory_pkg;

  // Controller states: sweeping the array, or serving external accesses.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // The only read latencies the read pipeline is built for.
  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 2;

  // Number of words addressed by an address of the given width.
  function automatic int unsigned depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage : memory_pkg

// File: rtl/memory_array_sync_read_pipe.sv
// Delay line for read data and its valid strobe.
// Each stage captures data only when its incoming valid is set, so the
// output word holds until the next valid read arrives.
module mem_read_pipe #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  for (genvar s = 0; s < LATENCY; s++) begin : g_stage
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;

    if (s == 0) begin : g_head
      assign in_valid = valid_i;
      assign in_data  = data_i;
    end else begin : g_tail
      assign in_valid = g_stage[s-1].valid_q;
      assign in_data  = g_stage[s-1].data_q;
    end

    // Stage register: valid always shifts, data only moves with a valid read.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= in_valid;
        if (in_valid) begin
          data_q <= in_data;
        end
      end
    end
  end

  assign valid_o = g_stage[LATENCY-1].valid_q;
  assign data_o  = g_stage[LATENCY-1].data_q;

endmodule : mem_read_pipe

// File: rtl/memory_array_sync.sv
// Synchronous single-port RAM with per-bit write mask, pipelined reads and a
// clear sequencer that sweeps INIT_VALUE through the array after reset or
// on clear_req. External accesses are only served once the sweep is done.
module memory_array_sync
  import memory_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 8,
  parameter int unsigned           ADDR_WIDTH   = 6,
  parameter int unsigned           READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  chip_enable,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] wr_mask,
  input  logic                  clear_req,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  ready
);

  localparam int unsigned DEPTH = depth(ADDR_WIDTH);

  if ((READ_LATENCY != RD_LAT_MIN) && (READ_LATENCY != RD_LAT_MAX)) begin : g_bad_latency
    $error("memory_array_sync: READ_LATENCY must be 1 or 2");
  end

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] sweep_addr_q, sweep_addr_d;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_mask;
  logic                  rd_accept;
  logic [DATA_WIDTH-1:0] rd_word;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // State and sweep address registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_CLEAR;
      sweep_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      sweep_addr_q <= sweep_addr_d;
    end
  end

  // Next-state logic and selection of who owns the write port this cycle.
  always_comb begin
    state_d      = state_q;
    sweep_addr_d = sweep_addr_q;
    mem_we       = 1'b0;
    mem_addr     = address;
    mem_wdata    = wr_data;
    mem_mask     = wr_mask;
    rd_accept    = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        mem_we       = 1'b1;
        mem_addr     = sweep_addr_q;
        mem_wdata    = INIT_VALUE;
        mem_mask     = '1;
        sweep_addr_d = sweep_addr_q + 1'b1;
        if (clear_req) begin
          sweep_addr_d = '0;
        end else if (sweep_addr_q == '1) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        mem_we    = chip_enable && write_enable;
        rd_accept = chip_enable && !write_enable;
        if (clear_req) begin
          state_d      = ST_CLEAR;
          sweep_addr_d = '0;
        end
      end
      default: begin
        state_d      = ST_CLEAR;
        sweep_addr_d = '0;
      end
    endcase
  end

  // Array write with per-bit mask; contents are initialised by the sweep.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_addr] <= (mem_q[mem_addr] & ~mem_mask) | (mem_wdata & mem_mask);
    end
  end

  assign rd_word = mem_q[address];

  mem_read_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .LATENCY    (READ_LATENCY)
  ) u_read_pipe (
    .clk     (clk),
    .rst     (rst),
    .valid_i (rd_accept),
    .data_i  (rd_word),
    .valid_o (rd_valid),
    .data_o  (rd_data)
  );

  assign ready = (state_q == ST_READY);

endmodule : memory_array_sync

// File: doc/memory_array_sync.md
Name: memory_array_sync

Overview:
Parametrised synchronous single-port RAM. It is the clocked successor to the team's 64x1 asynchronous memory chip, generalised to DATA_WIDTH x 2^ADDR_WIDTH.
- Adds per-bit write masking, a configurable read pipeline with a valid strobe, and a hardware clear sequencer.
- The clear sequencer zeroes (or presets) the whole array after reset or on request.
- Used as the storage element under bus/CPU-side memory controllers.

Parameters:
DATA_WIDTH, 8, bits per word (>=1)
ADDR_WIDTH, 6, address bits; depth = 2^ADDR_WIDTH words
READ_LATENCY, 1, cycles from accepted read to rd_valid; legal values 1 or 2
INIT_VALUE, 0, word value written to every location by the clear sweep (DATA_WIDTH bits)

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
chip_enable  input  1  access request this cycle
write_enable  input  1  1 = write, 0 = read (sampled only with chip_enable)
address  input  ADDR_WIDTH  word address
wr_data  input  DATA_WIDTH  write data
wr_mask  input  DATA_WIDTH  per-bit write mask, 1 = update bit
clear_req  input  1  one-cycle pulse; restarts clear sweep
rd_data  output  DATA_WIDTH  read data, held until next rd_valid
rd_valid  output  1  one-cycle pulse, rd_data valid
ready  output  1  1 = array accepts accesses (sweep complete)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: rd_data=0, rd_valid=0, ready=0, pipeline valid bits=0, sweep counter=0, state=ST_CLEAR. Array contents are not reset directly; the sweep initialises them.
- FSM has two states, ST_CLEAR and ST_READY.
- ST_CLEAR:
  - Each cycle writes INIT_VALUE (full mask) to sweep_addr, then increments sweep_addr.
  - After writing address 2^ADDR_WIDTH-1, go to ST_READY.
  - The sweep takes exactly 2^ADDR_WIDTH cycles. ready rises on the following cycle, i.e. 2^ADDR_WIDTH cycles after rst deasserts.
  - External accesses are ignored (no write, no rd_valid).
- ST_READY, ready=1:
  - chip_enable && write_enable: at the clock edge, mem[address] = (mem & ~wr_mask) | (wr_data & wr_mask).
  - chip_enable && !write_enable: read is accepted. rd_valid pulses exactly READ_LATENCY cycles later with mem[address] as sampled at the accept edge.
  - One access per cycle; back-to-back reads are fully pipelined.
- Write-then-read: a read accepted on the cycle after a write to the same address returns the new data. There is no same-cycle hazard because the block is single-port.
- clear_req:
  - In ST_READY, it drops ready on the next cycle and restarts the sweep from address 0. An access presented in the same cycle as clear_req is still performed.
  - Reads already in the pipeline complete normally and deliver their rd_valid.
  - clear_req during ST_CLEAR restarts the sweep at address 0.
- Reset mid-operation: async rst kills in-flight reads (rd_valid never asserts for them) and restarts the sweep after deassert.
- wr_mask=0: the write is a no-op. It still consumes the cycle.
- Address wraps naturally; there are no out-of-range addresses.

Decomposition:
- Package memory_pkg holds:
  - state enum {ST_CLEAR, ST_READY};
  - localparam DEPTH = 1<<ADDR_WIDTH helper;
  - legal READ_LATENCY constants (1, 2), used by an elaboration check.
- Sub-module mem_read_pipe holds the valid/data delay line of READ_LATENCY stages, with async reset on the valid bits.
- The array and FSM stay in memory_array_sync.

Test Plan (DATA_WIDTH=8, ADDR_WIDTH=6, READ_LATENCY=2):
1. Release rst, hold chip_enable=0 -> ready=0 for 64 cycles, ready=1 from cycle 64. Then read addr 0x00 and 0x3F -> rd_data=0x00 with rd_valid 2 cycles after each accept.
2. Write 0xA5 to addr 0x2B with mask 0xFF, then read 0x2B next cycle -> rd_valid 2 cycles later, rd_data=0xA5.
3. Masked write 0x0F with mask 0x0F to 0x2B (holding 0xA5), then read -> 0xAF. Write with mask 0x00 -> read still 0xAF.
4. Write 0x11 to 0x01 and 0x22 to 0x02, then consecutive reads 0x01, 0x02, 0x01 -> rd_valid high 3 consecutive cycles with data 0x11, 0x22, 0x11.
5. Issue read at 0x2B then clear_req next cycle -> rd_valid delivered with 0xAF; ready=0 for 64 cycles; then read 0x2B -> 0x00. Reads attempted while ready=0 -> no rd_valid.
6. Assert rst at sweep cycle 20 and release -> ready rises exactly 64 cycles after release. Assert rst during an in-flight read -> rd_valid stays 0 and rd_data=0.
